// File: rtl/seq_divider_8bit.sv
// Sequential 8-bit unsigned restoring divider with registered 7-segment readout.
// Optional macro DIV_ZERO_CHECK_EN: short-circuit a zero divisor straight to HOLD with DivByZero set.
module seq_divider_8bit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Load_Dvd,
    input  logic       Load_Dvs,
    input  logic [7:0] S,
    output logic [7:0] Quot,
    output logic [7:0] Rem,
    output logic       Busy,
    output logic       Done,
    output logic       DivByZero,
    output logic [6:0] QhexU,
    output logic [6:0] QhexL,
    output logic [6:0] RhexU,
    output logic [6:0] RhexL
);

    typedef enum logic [1:0] {IDLE, SHIFT, SUB, HOLD} state_t;

    state_t     r_state;
    logic [7:0] r_q;
    logic [7:0] r_d;
    logic [8:0] r_r;
    logic [2:0] r_k;
    logic       r_busy;
    logic       r_done;
    logic       r_dbz;

    logic [8:0] w_diff;
    logic       w_load;

    assign w_diff = r_r - {1'b0, r_d};
    assign w_load = Load_Dvd | Load_Dvs;

    // Active-low segment decode, bit 6 = g ... bit 0 = a
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Load_Dvd) begin
                        r_q <= S;
                        r_r <= '0;
                    end
                    if (Load_Dvs)
                        r_d <= S;
                    if (!w_load && Run) begin
`ifdef DIV_ZERO_CHECK_EN
                        if (r_d == '0) begin
                            r_q     <= '1;
                            r_r     <= {1'b0, r_q};
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= HOLD;
                        end else
`endif
                        begin
                            r_k     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_r     <= {r_r[7:0], r_q[7]};
                    r_q     <= {r_q[6:0], 1'b0};
                    r_state <= SUB;
                end
                SUB: begin
                    // Negative trial difference leaves R untouched: that is the restore step
                    if (!w_diff[8]) begin
                        r_r    <= w_diff;
                        r_q[0] <= 1'b1;
                    end
                    if (r_k == 3'd7) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= SHIFT;
                    end
                end
                HOLD: begin
                    if (w_load || !Run) begin
                        if (Load_Dvd) begin
                            r_q <= S;
                            r_r <= '0;
                        end
                        if (Load_Dvs)
                            r_d <= S;
                        r_done  <= 1'b0;
                        r_dbz   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            QhexU <= 7'h40;
            QhexL <= 7'h40;
            RhexU <= 7'h40;
            RhexL <= 7'h40;
        end else begin
            QhexU <= hex7(r_q[7:4]);
            QhexL <= hex7(r_q[3:0]);
            RhexU <= hex7(r_r[7:4]);
            RhexL <= hex7(r_r[3:0]);
        end
    end

    assign Quot      = r_q;
    assign Rem       = r_r[7:0];
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Scoreboard bench for seq_divider_8bit: directed boundary cases, mid-run disturbances, random divisions.
module tb_seq_divider_8bit;

    logic       Clk = 1'b0;
    logic       Reset, Run, Load_Dvd, Load_Dvs;
    logic [7:0] S;
    logic [7:0] Quot, Rem;
    logic       Busy, Done, DivByZero;
    logic [6:0] QhexU, QhexL, RhexU, RhexL;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    seq_divider_8bit dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Load_Dvd(Load_Dvd), .Load_Dvs(Load_Dvs), .S(S),
        .Quot(Quot), .Rem(Rem), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
        .QhexU(QhexU), .QhexL(QhexL), .RhexU(RhexU), .RhexL(RhexL)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] dvd, input logic [7:0] dvs);
        S = dvd; Load_Dvd = 1'b1; tick(); Load_Dvd = 1'b0;
        S = dvs; Load_Dvs = 1'b1; tick(); Load_Dvs = 1'b0;
    endtask

    task automatic check_hex(input string tag, input logic [7:0] q, input logic [7:0] r);
        check({tag, " qhexU"}, QhexU, seg(q[7:4]));
        check({tag, " qhexL"}, QhexL, seg(q[3:0]));
        check({tag, " rhexU"}, RhexU, seg(r[7:4]));
        check({tag, " rhexL"}, RhexL, seg(r[3:0]));
    endtask

    // lat = clock edges after the start edge until Done is seen
    task automatic divide(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                          input bit inject, input bit keep_run);
        exp_t e, g;
        int   n;
        load(dvd, dvs);
        if (dvs == 8'd0) begin
            e.q = 8'hFF;
            e.r = dvd;
        end else begin
            e.q = dvd / dvs;
            e.r = dvd % dvs;
        end
`ifdef DIV_ZERO_CHECK_EN
        e.dbz = (dvs == 8'd0);
        e.lat = (dvs == 8'd0) ? 0 : 16;
`else
        e.dbz = 1'b0;
        e.lat = 16;
`endif
        sb.push_back(e);
        Run = 1'b1;
        tick();
        if (!keep_run) Run = 1'b0;
        if (e.lat != 0) check({tag, " busy"}, Busy, 1'b1);
        n = 0;
        while (!Done && n < 40) begin
            if (inject && n == 4) begin
                S = 8'h03; Load_Dvs = 1'b1; Load_Dvd = 1'b1;
            end else begin
                Load_Dvs = 1'b0; Load_Dvd = 1'b0;
            end
            tick();
            n++;
        end
        Load_Dvs = 1'b0; Load_Dvd = 1'b0;
        g = sb.pop_front();
        check({tag, " latency"}, n, g.lat);
        check({tag, " done"}, Done, 1'b1);
        check({tag, " quot"}, Quot, g.q);
        check({tag, " rem"}, Rem, g.r);
        check({tag, " dbz"}, DivByZero, g.dbz);
        check({tag, " busy_end"}, Busy, 1'b0);
        if (keep_run) begin
            repeat (3) tick();
            check({tag, " hold_done"}, Done, 1'b1);
            check({tag, " hold_busy"}, Busy, 1'b0);
            check({tag, " hold_quot"}, Quot, g.q);
            Run = 1'b0;
        end
        tick();
        check({tag, " done_clr"}, Done, 1'b0);
        check({tag, " dbz_clr"}, DivByZero, 1'b0);
        check_hex(tag, g.q, g.r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Run = 1'b0; Load_Dvd = 1'b0; Load_Dvs = 1'b0; S = '0;
        repeat (2) tick();
        check("rst quot", Quot, 8'h00);
        check("rst rem", Rem, 8'h00);
        check("rst busy", Busy, 1'b0);
        check("rst done", Done, 1'b0);
        check("rst dbz", DivByZero, 1'b0);
        check_hex("rst", 8'h00, 8'h00);
        Reset = 1'b0;
        tick();

        divide("100/7", 8'd100, 8'd7, 1'b0, 1'b0);
        divide("255/1", 8'd255, 8'd1, 1'b0, 1'b0);
        divide("5/9", 8'd5, 8'd9, 1'b0, 1'b0);
        divide("255/255", 8'd255, 8'd255, 1'b0, 1'b0);
        divide("42/0", 8'd42, 8'd0, 1'b0, 1'b0);
        divide("inject", 8'd100, 8'd7, 1'b1, 1'b0);
        divide("runhold", 8'd200, 8'd13, 1'b0, 1'b1);

        load(8'd100, 8'd7);
        Run = 1'b1; tick(); Run = 1'b0;
        repeat (6) tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("midrst quot", Quot, 8'h00);
        check("midrst rem", Rem, 8'h00);
        check("midrst busy", Busy, 1'b0);
        check("midrst done", Done, 1'b0);
        check_hex("midrst", 8'h00, 8'h00);
        tick();
        check("midrst idle_busy", Busy, 1'b0);

        for (int i = 0; i < 6; i++)
            divide("rnd", 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider_8bit.md
# seq_divider_8bit

Sequential 8-bit unsigned restoring divider. It computes quotient and remainder of a switch-loaded dividend and divisor using an alternating shift / trial-subtract state machine, one bit per shift+subtract pair. It drives four registered 7-segment digits through the existing HexDriver. It is the inverse datapath of the lab's shift-add multiplier and sits at the same board level, on the same switches, buttons and hex displays.

## Interface
- No parameters; width fixed at 8.
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; clears all state.
- Run  input  1  level; starts a division when sampled high in IDLE.
- Load_Dvd  input  1  load S as dividend; clears remainder.
- Load_Dvs  input  1  load S as divisor.
- S  input  8  switch data.
- Quot  output  8  quotient register (Q).
- Rem  output  8  remainder, R[7:0].
- Busy  output  1  high in SHIFT or SUB.
- Done  output  1  high in HOLD.
- DivByZero  output  1  divide-by-zero flag; see Configuration.
- QhexU, QhexL, RhexU, RhexL  output  7 each  registered HexDriver decode of Quot[7:4], Quot[3:0], Rem[7:4], Rem[3:0].

## Operation
- Registers: Q[7:0], R[8:0] (9-bit partial remainder), D[7:0], 3-bit iteration counter k, state.
- States: IDLE, SHIFT, SUB, HOLD.
- IDLE:
  - Load_Dvd → Q<=S, R<=0.
  - Load_Dvs → D<=S.
  - Both asserted → both loads happen.
  - Any load has priority over Run; no start that cycle.
  - Run=1 with no load → k<=0, go to SHIFT.
- SHIFT: R<={R[7:0],Q[7]}, Q<={Q[6:0],1'b0}; go to SUB.
- SUB:
  - diff = R − {1'b0,D}, 9-bit.
  - If diff[8]==0: R<=diff, Q[0]<=1. Otherwise R and Q are unchanged (restore).
  - If k==7, go to HOLD; else k<=k+1 and go to SHIFT.
- HOLD:
  - Results held.
  - Run=0 → IDLE.
  - Any load → perform the load and go to IDLE; Done and DivByZero clear.
- Loads are ignored in SHIFT and SUB.
- Run held high through HOLD does not restart; Run must drop before the next start.
- Invariant: R < 2·D after every SHIFT, so 9 bits suffice. Final R < D ≤ 255, and Rem = R[7:0].
- Quot and Rem are direct register outputs. They change during computation and are valid only while Done=1.

## Timing
- Reset (synchronous): state=IDLE; Q, R, D, k = 0; Busy=Done=DivByZero=0. All hex outputs load 7'h40 (digit '0', active-low) on the reset edge.
- Start edge E0 (Run sampled high in IDLE): state enters SHIFT. Busy high from after E0 to E16.
- Iteration k performs SHIFT at edge E(2k+1) and SUB at edge E(2k+2).
- Done rises after E16. Latency is 16 cycles from the start edge to Done.
- Hex outputs lag Quot/Rem by one cycle.
- Reset mid-division: next edge returns to IDLE with all registers zeroed. No partial result is retained.
- Reset has priority over Run and over both loads.

## Configuration
- DIV_ZERO_CHECK_EN defined: Run in IDLE with D==0 goes to HOLD at E0. It sets Q<=8'hFF, R<=dividend (Q), DivByZero<=1, and Done is high after one cycle. DivByZero clears on leaving HOLD or on Reset.
- DIV_ZERO_CHECK_EN undefined: no check is made. The 16-cycle algorithm runs naturally and yields the same Quot=8'hFF, Rem=dividend. DivByZero is tied to 0.

## Test plan
- 100 / 7: Load_Dvd S=8'h64, Load_Dvs S=8'h07, pulse Run → Busy 16 cycles, then Done=1, Quot=8'h0E, Rem=8'h02. One cycle later QhexU/QhexL show "0E" and RhexU/RhexL show "02".
- Boundaries, each Done after 16 cycles:
  - 255 / 1 → Quot=8'hFF, Rem=8'h00.
  - 5 / 9 → Quot=8'h00, Rem=8'h05.
  - 255 / 255 → Quot=8'h01, Rem=8'h00.
- 42 / 0 with DIV_ZERO_CHECK_EN → Done one cycle after the start edge, DivByZero=1, Quot=8'hFF, Rem=8'h2A. Without the macro → Done after 16 cycles, same values, DivByZero=0.
- Assert Load_Dvs S=8'h03 at cycle 5 of 100/7 → ignored; result is still 8'h0E rem 8'h02.
- Hold Run high through HOLD → stays in HOLD with no restart. Drop Run → IDLE, Done=0.
- Pulse Reset at cycle 7 of a division → next cycle IDLE, Quot=Rem=0, Busy=Done=0. Hex outputs show 7'h40.
